ram_dump_ctrl: RTL and testbench

Sequences the read-out of one channel's capture RAM to the host after a capture completes. It walks the circular sample buffer from the oldest sample, through ENTRIES samples, wrapping at ENTRIES-1. Each byte goes to the UART transmitter over the resp/send_resp/resp_sent handshake. The block sits between the command interpreter, which issues dump requests, the five channel RAMs, which share raddr, and the UART transmit path.

---
 rtl/ram_dump_ctrl_if.sv | 34 +++
 rtl/ram_dump_ctrl.sv | 114 +++++++++++
 tb/tb_ram_dump_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ram_dump_ctrl_if.sv
// Bundles the dump command, channel RAM read port and UART byte handshake
// seen by ram_dump_ctrl.
interface ram_dump_ctrl_if #(
    parameter int LOG2 = 9
);
    logic            dump_req;
    logic [2:0]      dump_ch;
    logic [LOG2-1:0] start_addr;
    logic [7:0]      rdataCH1;
    logic [7:0]      rdataCH2;
    logic [7:0]      rdataCH3;
    logic [7:0]      rdataCH4;
    logic [7:0]      rdataCH5;
    logic            resp_sent;
    logic [LOG2-1:0] raddr;
    logic [7:0]      resp;
    logic            send_resp;
    logic            dump_busy;
    logic            dump_done;

    modport slave (
        input  dump_req, dump_ch, start_addr,
        input  rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5,
        input  resp_sent,
        output raddr, resp, send_resp, dump_busy, dump_done
    );

    modport master (
        output dump_req, dump_ch, start_addr,
        output rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5,
        output resp_sent,
        input  raddr, resp, send_resp, dump_busy, dump_done
    );
endinterface

// File: rtl/ram_dump_ctrl.sv
// Streams one channel's circular capture RAM to the UART, oldest sample
// first, one byte per resp/send_resp/resp_sent handshake.
module ram_dump_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_dump_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, SEND, WAIT} state_t;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   ENT  = (LOG2 + 1)'(ENTRIES);

    state_t          state_q, state_d;
    logic [2:0]      ch_q, ch_d;
    logic            nak_q, nak_d;
    logic [LOG2-1:0] cnt_q, cnt_d;
    logic [LOG2-1:0] raddr_q, raddr_d;
    logic [7:0]      resp_q, resp_d;
    logic            send_q, send_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      rdata_sel;

    always_comb begin
        rdata_sel = 8'hEE;
        case (ch_q)
            3'd1:    rdata_sel = bus.rdataCH1;
            3'd2:    rdata_sel = bus.rdataCH2;
            3'd3:    rdata_sel = bus.rdataCH3;
            3'd4:    rdata_sel = bus.rdataCH4;
            3'd5:    rdata_sel = bus.rdataCH5;
            default: rdata_sel = 8'hEE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        nak_d   = nak_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        resp_d  = resp_q;
        busy_d  = busy_q;
        send_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dump_req) begin
                    ch_d    = bus.dump_ch;
                    nak_d   = !(bus.dump_ch inside {[3'd1:3'd5]});
                    raddr_d = ({1'b0, bus.start_addr} >= ENT) ? '0 : bus.start_addr;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RD;
                end
            end
            RD: state_d = SEND;
            SEND: begin
                resp_d  = nak_q ? 8'hEE : rdata_sel;
                send_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // resp_sent coincident with the send strobe belongs to no byte yet
                if (bus.resp_sent && !send_q) begin
                    if (nak_q || cnt_q == LAST) begin
                        nak_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        raddr_d = (raddr_q == LAST) ? '0 : raddr_q + 1'b1;
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            nak_q   <= 1'b0;
            cnt_q   <= '0;
            raddr_q <= '0;
            resp_q  <= 8'h00;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            nak_q   <= nak_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            resp_q  <= resp_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.raddr     = raddr_q;
    assign bus.resp      = resp_q;
    assign bus.send_resp = send_q;
    assign bus.dump_busy = busy_q;
    assign bus.dump_done = done_q;
endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Directed bench for ram_dump_ctrl: RAM and UART models, byte/address
// scoreboard against hand-derived sequences.
module tb_ram_dump_ctrl;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    ram_dump_ctrl_if #(.LOG2(LOG2)) bus ();
    ram_dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nchk = 0, nerr = 0;
    int pat = 0, uart_dly = 10, stray = 0;
    int ucnt = 0, stray_left = 0, cyc = 0, t_rs = 0, t_done = 0, ndone = 0;
    logic saw384 = 0;
    logic [7:0] held = 0;
    logic [7:0] bq[$];
    logic [8:0] aq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int mode, input int ch, input logic [8:0] a);
        logic [2:0] c;
        c = 3'(ch);
        return (mode == 0) ? a[7:0] : {c, a[4:0]};
    endfunction

    always @(posedge clk) begin
        bus.rdataCH1 <= pat_byte(pat, 1, bus.raddr);
        bus.rdataCH2 <= pat_byte(pat, 2, bus.raddr);
        bus.rdataCH3 <= pat_byte(pat, 3, bus.raddr);
        bus.rdataCH4 <= pat_byte(pat, 4, bus.raddr);
        bus.rdataCH5 <= pat_byte(pat, 5, bus.raddr);
    end

    // UART model plus send/done monitor
    always @(posedge clk) begin
        logic rs;
        #1;
        cyc++;
        rs = 0;
        if (bus.raddr == 9'd384) saw384 = 1;
        if (!rst_n) begin
            ucnt = 0;
            stray_left = 0;
        end else begin
            if (stray_left > 0) begin rs = 1; stray_left--; end
            if (bus.send_resp) begin
                bq.push_back(bus.resp);
                aq.push_back(bus.raddr);
                held = bus.resp;
                ucnt = uart_dly;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    chk("resp_hold", {24'h0, bus.resp}, {24'h0, held});
                    rs = 1;
                    t_rs = cyc;
                    if (stray != 0) stray_left = 2;
                end
            end
            if (bus.dump_done) begin ndone++; t_done = cyc; end
        end
        bus.resp_sent = rs;
    end

    task automatic start_dump(input int ch, input int sa);
        int eff;
        eff = (sa >= ENTRIES) ? 0 : sa;
        bq.delete();
        aq.delete();
        @(posedge clk); #2;
        bus.dump_req = 1; bus.dump_ch = 3'(ch); bus.start_addr = 9'(sa);
        @(posedge clk); #2;
        bus.dump_req = 0; bus.dump_ch = 3'(ch + 1); bus.start_addr = 9'(sa + 3);
        chk("e0_busy", {31'h0, bus.dump_busy}, 1);
        chk("e0_raddr", {23'h0, bus.raddr}, eff);
        @(posedge clk); #2;
        chk("e1_send", {31'h0, bus.send_resp}, 0);
        @(posedge clk); #2;
        chk("e2_send", {31'h0, bus.send_resp}, 1);
    endtask

    task automatic wait_done();
        int d0, n;
        d0 = ndone - ((bus.dump_done === 1'b1) ? 1 : 0);
        n = 0;
        while (ndone == d0 && n < 20000) begin @(posedge clk); #2; n++; end
        chk("done_timeout", {31'h0, (n >= 20000)}, 0);
        repeat (4) @(posedge clk);
        #2;
        chk("done_once", ndone - d0, 1);
        chk("busy_after", {31'h0, bus.dump_busy}, 0);
    endtask

    task automatic verify(input int ch, input int sa, input int mode, input int nak);
        int n, eff, a;
        n = nak ? 1 : ENTRIES;
        eff = (sa >= ENTRIES) ? 0 : sa;
        chk("nbytes", bq.size(), n);
        for (int i = 0; i < n && i < bq.size(); i++) begin
            a = (eff + i) % ENTRIES;
            chk("byte", {24'h0, bq[i]}, nak ? 32'hEE : {24'h0, pat_byte(mode, ch, 9'(a))});
            if (!nak) chk("raddr", {23'h0, aq[i]}, a);
        end
    endtask

    initial begin
        bus.dump_req = 0; bus.dump_ch = 0; bus.start_addr = 0;
        #3;
        chk("rst_outs", {bus.raddr, bus.resp, bus.send_resp, bus.dump_busy, bus.dump_done}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // basic dump, identity pattern, slow UART
        pat = 0; uart_dly = 10;
        start_dump(3, 0); wait_done(); verify(3, 0, 0, 0);

        // wrap-around from 380
        uart_dly = 3;
        start_dump(1, 380); wait_done(); verify(1, 380, 0, 0);

        // invalid channels
        pat = 1;
        start_dump(0, 5); wait_done(); verify(0, 5, 1, 1);
        chk("nak0_done_lat", t_done - t_rs, 1);
        start_dump(7, 5); wait_done(); verify(7, 5, 1, 1);
        chk("nak7_done_lat", t_done - t_rs, 1);

        // stray dump_req and resp_sent during RD/SEND
        stray = 1;
        start_dump(5, 0);
        begin
            int n;
            n = 0;
            while (bq.size() < 50 && n < 5000) begin @(posedge clk); #2; n++; end
            bus.dump_req = 1; bus.dump_ch = 3'd2; bus.start_addr = 9'd7;
            @(posedge clk); #2;
            bus.dump_req = 0;
        end
        wait_done(); verify(5, 0, 1, 0);
        stray = 0;

        // reset mid-dump while in WAIT
        start_dump(4, 0);
        begin
            int n;
            n = 0;
            while (bq.size() < 101 && n < 5000) begin @(posedge clk); #2; n++; end
            @(posedge clk); #3;
            rst_n = 0;
            #1;
            chk("mid_rst_outs", {bus.raddr, bus.resp, bus.send_resp, bus.dump_busy, bus.dump_done}, 0);
            repeat (2) @(posedge clk);
            #2 rst_n = 1;
        end
        start_dump(4, 10); wait_done(); verify(4, 10, 1, 0);

        // start address out of range maps to 0
        start_dump(2, 400); wait_done(); verify(2, 400, 1, 0);

        // channel mux
        for (int c = 1; c <= 5; c++) begin
            start_dump(c, 17 * c); wait_done(); verify(c, 17 * c, 1, 0);
        end

        chk("raddr_never_384", {31'h0, saw384}, 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
